// File: rtl/adder_operand_sequencer_if.sv
// Handshake and adder-side bus of the operand sequencer.
// The sequencer is the slave; the environment (upstream, adder, downstream) is the master.
interface adder_operand_sequencer_if #(
  parameter int WIDTH = 32
);
  // Synchronous abort
  logic             i_clear;
  // Upstream operand stream
  logic             i_valid;
  logic [WIDTH-1:0] i_data;
  logic             o_ready;
  // Ripple adder connection
  logic [WIDTH-1:0] o_add1;
  logic [WIDTH-1:0] o_add2;
  logic [WIDTH:0]   i_sum;
  // Downstream result
  logic [WIDTH:0]   o_result;
  logic             o_result_valid;
  logic             i_result_ready;
  logic             o_overflow;
  logic [7:0]       o_op_count;

  modport slave (
    input  i_clear,
    input  i_valid,
    input  i_data,
    output o_ready,
    output o_add1,
    output o_add2,
    input  i_sum,
    output o_result,
    output o_result_valid,
    input  i_result_ready,
    output o_overflow,
    output o_op_count
  );

  modport master (
    output i_clear,
    output i_valid,
    output i_data,
    input  o_ready,
    input  o_add1,
    input  o_add2,
    output i_sum,
    input  o_result,
    input  o_result_valid,
    output i_result_ready,
    input  o_overflow,
    input  o_op_count
  );
endinterface

// File: rtl/adder_operand_sequencer.sv
// Operand sequencer for a combinational ripple adder: collects operand A then B
// from an upstream valid/ready stream, gives the adder one full clock period to
// settle, captures the WIDTH+1 bit sum and holds it until downstream consumes it.
module adder_operand_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  adder_operand_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    S_LOAD_A  = 2'd0,
    S_LOAD_B  = 2'd1,
    S_CAPTURE = 2'd2,
    S_OUTPUT  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] add1_q, add1_d;
  logic [WIDTH-1:0] add2_q, add2_d;
  logic [WIDTH:0]   result_q, result_d;
  logic [7:0]       cnt_q, cnt_d;

  logic ready;
  logic result_valid;
  logic accept;
  logic consume;

  // Completed-operation counter wraps naturally at 256.
  function automatic logic [7:0] count_inc(input logic [7:0] c);
    return c + 8'd1;
  endfunction

  // Carry-out of the adder is the top bit of the captured sum.
  function automatic logic carry_of(input logic [WIDTH:0] r);
    return r[WIDTH];
  endfunction

  assign accept  = bus.i_valid & ready;
  assign consume = result_valid & bus.i_result_ready;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_LOAD_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides every other transition
  always_comb begin
    state_d = state_q;
    if (bus.i_clear) begin
      state_d = S_LOAD_A;
    end else begin
      case (state_q)
        S_LOAD_A:  if (accept)  state_d = S_LOAD_B;
        S_LOAD_B:  if (accept)  state_d = S_CAPTURE;
        S_CAPTURE:              state_d = S_OUTPUT;
        S_OUTPUT:  if (consume) state_d = S_LOAD_A;
      endcase
    end
  end

  // Output decode from state only, so o_ready never depends on i_valid
  always_comb begin
    ready        = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      S_LOAD_A:  ready        = 1'b1;
      S_LOAD_B:  ready        = 1'b1;
      S_CAPTURE: ;
      S_OUTPUT:  result_valid = 1'b1;
    endcase
  end

  // Datapath next values: operand loads, sum capture and consume counting
  always_comb begin
    add1_d   = add1_q;
    add2_d   = add2_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    if (bus.i_clear) begin
      // Words presented together with clear are dropped; the count survives.
      add1_d   = '0;
      add2_d   = '0;
      result_d = '0;
    end else begin
      if (accept && state_q == S_LOAD_A) add1_d = bus.i_data;
      if (accept && state_q == S_LOAD_B) add2_d = bus.i_data;
      // Operands were stable for the whole S_CAPTURE cycle, so the adder has settled.
      if (state_q == S_CAPTURE)          result_d = bus.i_sum;
      if (consume)                       cnt_d    = count_inc(cnt_q);
    end
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      add1_q   <= '0;
      add2_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      add1_q   <= add1_d;
      add2_q   <= add2_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.o_ready        = ready;
  assign bus.o_add1         = add1_q;
  assign bus.o_add2         = add2_q;
  assign bus.o_result       = result_q;
  assign bus.o_result_valid = result_valid;
  assign bus.o_overflow     = result_valid & carry_of(result_q);
  assign bus.o_op_count     = cnt_q;

endmodule

// File: doc/adder_operand_sequencer.md
ADDER_OPERAND_SEQUENCER -- requirements
Module: adder_operand_sequencer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, which is the operand width of the downstream ripple adder.
REQ-002 The module SHALL have port i_clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port i_clear, input, 1 bit: synchronous abort of the current operation.
REQ-005 The module SHALL have port i_valid, input, 1 bit: upstream operand word valid.
REQ-006 The module SHALL have port i_data, input, WIDTH bits: upstream operand word.
REQ-007 The module SHALL have port o_ready, output, 1 bit: sequencer can accept an operand word.
REQ-008 The module SHALL have port o_add1, output, WIDTH bits: registered operand A, driven to the adder's i_add1.
REQ-009 The module SHALL have port o_add2, output, WIDTH bits: registered operand B, driven to the adder's i_add2.
REQ-010 The module SHALL have port i_sum, input, WIDTH+1 bits: combinational result from the adder's o_result.
REQ-011 The module SHALL have port o_result, output, WIDTH+1 bits: captured sum, MSB = carry-out.
REQ-012 The module SHALL have port o_result_valid, output, 1 bit: o_result holds an unconsumed sum.
REQ-013 The module SHALL have port i_result_ready, input, 1 bit: downstream consumes o_result.
REQ-014 The module SHALL have port o_overflow, output, 1 bit: equals o_result[WIDTH] whenever o_result_valid=1, and 0 otherwise.
REQ-015 The module SHALL have port o_op_count, output, 8 bits: number of completed (consumed) additions, wrapping modulo 256.

Function
REQ-016 The FSM SHALL have exactly four states: S_LOAD_A, S_LOAD_B, S_CAPTURE and S_OUTPUT.
REQ-017 o_ready SHALL be 1 in S_LOAD_A and S_LOAD_B only, decoded from state with no combinational path from i_valid.
REQ-018 An accept SHALL occur when i_valid=1 and o_ready=1 on a rising edge.
REQ-019 An accept in S_LOAD_A SHALL register i_data into o_add1 and move the FSM to S_LOAD_B.
REQ-020 An accept in S_LOAD_B SHALL register i_data into o_add2 and move the FSM to S_CAPTURE.
REQ-021 Without an accept, the FSM SHALL stay in its current state and o_add1/o_add2 SHALL hold.
REQ-022 S_CAPTURE SHALL last exactly one cycle: o_result <= i_sum (adder settle time = one clock period), then the FSM SHALL go to S_OUTPUT.
REQ-023 o_result_valid SHALL be 1 exactly while in S_OUTPUT; o_result SHALL be stable while o_result_valid=1.
REQ-024 In S_OUTPUT with i_result_ready=1, the FSM SHALL go to S_LOAD_A and increment o_op_count by 1 (255 -> 0).
REQ-025 In S_OUTPUT with i_result_ready=0, the FSM SHALL hold indefinitely.
REQ-026 Latency SHALL be: operand B accepted at edge N, o_result_valid=1 after edge N+1, next operand A acceptable no earlier than the cycle after consumption.
REQ-027 o_add1 and o_add2 SHALL be held through S_CAPTURE and S_OUTPUT, and are only overwritten by a new accept.
REQ-028 i_clear=1 on an edge SHALL force S_LOAD_A, clear o_result, o_add1 and o_add2 to 0, and leave o_op_count unchanged; it SHALL take priority over any accept or consume in the same cycle, and a word presented with i_clear=1 SHALL be dropped.
REQ-029 Arithmetic SHALL be unsigned, and o_result SHALL be WIDTH+1 bits wide with no truncation.

Reset
REQ-030 While i_rst_n=0, asynchronously: state=S_LOAD_A; o_add1, o_add2 and o_result=0; o_result_valid=0; o_overflow=0; o_op_count=0.
REQ-031 Consequently, o_ready SHALL be 1 during and immediately after reset.
REQ-032 Reset asserted mid-operation (any state) SHALL discard partial operands and any pending result, with no consume counted.
REQ-033 Reset deassertion SHALL take effect on the first rising edge after i_rst_n rises.

Verification
REQ-034 A bench SHALL cover: WIDTH=32, A=0x0000_0005, B=0x0000_0007, i_result_ready=1 -> o_result=0x0_0000_000C, o_overflow=0, o_result_valid high exactly 1 cycle, o_op_count=1.
REQ-035 A bench SHALL cover: A=0xFFFF_FFFF, B=0x0000_0001 -> o_result=0x1_0000_0000, o_overflow=1.
REQ-036 A bench SHALL cover: i_result_ready=0 for 10 cycles after valid -> o_result_valid stays 1, o_result stable, o_ready=0, with extra i_valid pulses ignored; then ready=1 -> exactly one consume.
REQ-037 A bench SHALL cover: i_valid gaps between A and B (3 idle cycles) -> same result as back-to-back; i_clear asserted in S_LOAD_B -> o_ready=1, the next two words form a fresh pair.
REQ-038 A bench SHALL cover: i_rst_n pulsed low in S_OUTPUT -> o_result_valid=0 immediately (async), o_op_count=0, state=S_LOAD_A.
REQ-039 A bench SHALL cover: 256 consumed additions -> o_op_count wraps to 0; random operand pairs are checked against the reference model A+B (WIDTH+1 bits).
